rv32i_wb_sched: RTL and testbench

Writeback scheduler and scoreboard for the RV32I register file. It arbitrates two writeback sources, the ALU/execute path and the load path, onto the register file's single write port. Arbitration is round-robin, and the granted write is registered onto wb_enable/wb_reg/wb_data. A per-register pending-write counter lets decode stall on RAW hazards (rs1_busy/rs2_busy) and refuse issue when a counter would overflow.

---
 rtl/rv32i_wb_sched_if.sv | 52 +++++
 rtl/rv32i_wb_sched.sv | 124 ++++++++++++
 tb/tb_rv32i_wb_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_wb_sched_if.sv
// Writeback scheduler bus: ALU/load writeback requests, decode issue/query
// ports and the register-file write port, bundled for the scheduler.
interface rv32i_wb_sched_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;

    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;

    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic        rs1_busy;
    logic        rs2_busy;

    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        idle;
    logic        err;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  rs1_reg, rs2_reg,
        output rs1_busy, rs2_busy,
        output wb_enable, wb_reg, wb_data, idle, err
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output issue_valid, issue_rd,
        input  issue_ready,
        output rs1_reg, rs2_reg,
        input  rs1_busy, rs2_busy,
        input  wb_enable, wb_reg, wb_data, idle, err
    );
endinterface

// File: rtl/rv32i_wb_sched.sv
// Round-robin writeback arbiter (ALU vs load) onto the single register-file
// write port, with a per-register pending-write scoreboard for decode.
//
// state   | meaning
// PRI_LD  | load wins the next contended cycle (reset state)
// PRI_ALU | ALU wins the next contended cycle
module rv32i_wb_sched #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    rv32i_wb_sched_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {PRI_LD = 1'b0, PRI_ALU = 1'b1} pri_t;

    pri_t pri_q, pri_d;

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic [CNT_W-1:0] cnt_v [0:31];

    logic        wb_enable_q;
    logic [4:0]  wb_reg_q;
    logic [31:0] wb_data_q;
    logic        err_q, err_d;

    logic        alu_ready, ld_ready, contend, accept;
    logic [4:0]  acc_rd;
    logic [31:0] acc_data;
    logic        issue_ready, issue_fire, commit_on_issue;
    logic        any_pending;

    // x0 never has a pending write; give it a constant zero slot for lookups
    always_comb begin
        cnt_v[0] = '0;
        for (int r = 1; r < 32; r++) cnt_v[r] = cnt_q[r];
    end

    always_ff @(posedge clk) begin
        if (reset) pri_q <= PRI_LD;
        else       pri_q <= pri_d;
    end

    always_comb begin
        pri_d     = pri_q;
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        contend   = bus.alu_valid && bus.ld_valid;
        if (!reset) begin
            if (pri_q == PRI_ALU) begin
                alu_ready = bus.alu_valid;
                ld_ready  = bus.ld_valid && !bus.alu_valid;
                if (contend) pri_d = PRI_LD;
            end else begin
                ld_ready  = bus.ld_valid;
                alu_ready = bus.alu_valid && !bus.ld_valid;
                if (contend) pri_d = PRI_ALU;
            end
        end
    end

    assign accept   = alu_ready || ld_ready;
    assign acc_rd   = alu_ready ? bus.alu_rd   : bus.ld_rd;
    assign acc_data = alu_ready ? bus.alu_data : bus.ld_data;

    // A commit landing on a saturated register frees a slot in the same cycle
    assign commit_on_issue = wb_enable_q && (wb_reg_q == bus.issue_rd);
    assign issue_ready = !reset &&
                         !((bus.issue_rd != 5'd0) &&
                           (cnt_v[bus.issue_rd] == CNT_MAX) &&
                           !commit_on_issue);
    assign issue_fire  = bus.issue_valid && issue_ready && (bus.issue_rd != 5'd0);

    always_comb begin
        err_d = err_q;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_fire && (bus.issue_rd == 5'(r)) &&
                !(wb_enable_q && (wb_reg_q == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (wb_enable_q && (wb_reg_q == 5'(r)) &&
                         !(issue_fire && (bus.issue_rd == 5'(r)))) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
            err_q       <= 1'b0;
            wb_enable_q <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
            err_q       <= err_d;
            wb_enable_q <= accept && (acc_rd != 5'd0);
            if (accept) begin
                wb_reg_q  <= acc_rd;
                wb_data_q <= acc_data;
            end
        end
    end

    always_comb begin
        any_pending = 1'b0;
        for (int r = 1; r < 32; r++) any_pending = any_pending || (cnt_q[r] != '0);
    end

    assign bus.alu_ready   = alu_ready;
    assign bus.ld_ready    = ld_ready;
    assign bus.issue_ready = issue_ready;
    assign bus.rs1_busy    = (cnt_v[bus.rs1_reg] != '0);
    assign bus.rs2_busy    = (cnt_v[bus.rs2_reg] != '0);
    assign bus.wb_enable   = wb_enable_q;
    assign bus.wb_reg      = wb_reg_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.idle        = !any_pending && !wb_enable_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_rv32i_wb_sched.sv
// Self-checking bench for rv32i_wb_sched: arbitration vector table, directed
// corner sequences, and randomized traffic against a pending-count model.
module tb_rv32i_wb_sched;
    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    rv32i_wb_sched_if bus();

    rv32i_wb_sched #(.CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clr_inputs();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_rd  = 0; bus.ld_data  = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
        bus.rs1_reg = 0; bus.rs2_reg = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    typedef struct {
        logic a_v;
        logic l_v;
        logic exp_ar;
        logic exp_lr;
    } arb_vec_t;

    arb_vec_t vecs [10];

    // Random-phase reference state
    int          pend [32];
    bit          m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_prio_alu;
    bit          a_act, l_act;
    int          owed [$];

    initial begin
        vecs[0] = '{1, 0, 1, 0};
        vecs[1] = '{0, 1, 0, 1};
        vecs[2] = '{1, 1, 0, 1};
        vecs[3] = '{1, 0, 1, 0};
        vecs[4] = '{1, 1, 1, 0};
        vecs[5] = '{1, 1, 0, 1};
        vecs[6] = '{0, 0, 0, 0};
        vecs[7] = '{0, 1, 0, 1};
        vecs[8] = '{1, 1, 1, 0};
        vecs[9] = '{1, 1, 0, 1};

        // Reset behaviour: readies held low while reset is high
        clr_inputs();
        reset = 1;
        bus.alu_valid = 1; bus.ld_valid = 1; bus.issue_valid = 1; bus.issue_rd = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_ready", bus.alu_ready, 0);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_issue_ready", bus.issue_ready, 0);
        clr_inputs();
        reset = 0;
        bus.rs1_reg = 5'd3; bus.rs2_reg = 5'd5;
        @(negedge clk);
        chk("rst_idle", bus.idle, 1);
        chk("rst_busy1", bus.rs1_busy, 0);
        chk("rst_busy2", bus.rs2_busy, 0);
        chk("rst_wb_enable", bus.wb_enable, 0);
        chk("rst_wb_reg", bus.wb_reg, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_err", bus.err, 0);

        // Arbitration table (rd = 0 so the scoreboard is untouched)
        step();
        for (int i = 0; i < 10; i++) begin
            bus.alu_valid = vecs[i].a_v; bus.alu_rd = 0; bus.alu_data = 32'h100 + i;
            bus.ld_valid  = vecs[i].l_v; bus.ld_rd  = 0; bus.ld_data  = 32'h200 + i;
            @(negedge clk);
            chk($sformatf("tbl%0d_alu_ready", i), bus.alu_ready, vecs[i].exp_ar);
            chk($sformatf("tbl%0d_ld_ready", i), bus.ld_ready, vecs[i].exp_lr);
            step();
            chk($sformatf("tbl%0d_wb_enable", i), bus.wb_enable, 0);
            if (vecs[i].exp_ar)      chk($sformatf("tbl%0d_wb_data", i), bus.wb_data, 32'h100 + i);
            else if (vecs[i].exp_lr) chk($sformatf("tbl%0d_wb_data", i), bus.wb_data, 32'h200 + i);
        end
        clr_inputs();

        // Contention after reset
        do_reset();
        bus.issue_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.issue_rd = (i % 2 == 0) ? 5'd5 : 5'd6;
            step();
        end
        bus.issue_valid = 0;
        bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hAAAA_0005;
        bus.ld_valid  = 1; bus.ld_rd  = 5'd6; bus.ld_data  = 32'h1111_0006;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_alu_ready", k), bus.alu_ready, (k % 2 == 1));
            chk($sformatf("cont%0d_ld_ready", k), bus.ld_ready, (k % 2 == 0));
            step();
            if (k == 3) begin bus.alu_valid = 0; bus.ld_valid = 0; end
            chk($sformatf("cont%0d_wb_enable", k), bus.wb_enable, 1);
            chk($sformatf("cont%0d_wb_reg", k), bus.wb_reg, (k % 2 == 1) ? 5 : 6);
            chk($sformatf("cont%0d_wb_data", k), bus.wb_data,
                (k % 2 == 1) ? 32'hAAAA_0005 : 32'h1111_0006);
        end
        step();
        chk("cont_idle", bus.idle, 1);
        chk("cont_err", bus.err, 0);

        // Scoreboard: busy until the write has landed
        bus.issue_valid = 1; bus.issue_rd = 5'd7;
        step();
        bus.issue_valid = 0; bus.rs1_reg = 5'd7;
        bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("sb_busy_pre", bus.rs1_busy, 1);
        chk("sb_alu_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 0;
        chk("sb_wb_enable", bus.wb_enable, 1);
        chk("sb_wb_reg", bus.wb_reg, 7);
        chk("sb_wb_data", bus.wb_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sb_busy_wb", bus.rs1_busy, 1);
        step();
        @(negedge clk);
        chk("sb_busy_after", bus.rs1_busy, 0);
        chk("sb_idle", bus.idle, 1);

        // Saturation of rd 3
        step();
        bus.issue_valid = 1; bus.issue_rd = 5'd3; bus.rs1_reg = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("sat_issue%0d_ready", i), bus.issue_ready, 1);
            step();
        end
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3333_0003;
        @(negedge clk);
        chk("sat_full_ready", bus.issue_ready, 0);
        chk("sat_alu_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 0;
        @(negedge clk);
        chk("sat_commit_ready", bus.issue_ready, 1);
        step();
        bus.issue_valid = 0;
        @(negedge clk);
        chk("sat_still_full", bus.issue_ready, 0);
        chk("sat_busy", bus.rs1_busy, 1);
        step();
        bus.ld_valid = 1; bus.ld_rd = 5'd3; bus.ld_data = 32'h3;
        repeat (3) step();
        bus.ld_valid = 0;
        repeat (2) step();
        @(negedge clk);
        chk("sat_idle", bus.idle, 1);
        chk("sat_err", bus.err, 0);

        // x0 handling
        step();
        bus.issue_valid = 1; bus.issue_rd = 5'd0;
        bus.ld_valid = 1; bus.ld_rd = 5'd0; bus.ld_data = 32'h1234;
        bus.rs1_reg = 5'd0;
        @(negedge clk);
        chk("x0_issue_ready", bus.issue_ready, 1);
        chk("x0_ld_ready", bus.ld_ready, 1);
        step();
        bus.issue_valid = 0; bus.ld_valid = 0;
        chk("x0_wb_enable", bus.wb_enable, 0);
        chk("x0_wb_data", bus.wb_data, 32'h1234);
        chk("x0_busy", bus.rs1_busy, 0);
        chk("x0_idle", bus.idle, 1);
        chk("x0_err", bus.err, 0);

        // Error on commit without issue, then reset mid-operation
        bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h9999;
        step();
        bus.alu_valid = 0;
        chk("err_wb_enable", bus.wb_enable, 1);
        chk("err_before", bus.err, 0);
        step();
        chk("err_set", bus.err, 1);
        step();
        chk("err_sticky", bus.err, 1);
        bus.issue_valid = 1; bus.issue_rd = 5'd4;
        repeat (2) step();
        bus.issue_valid = 0;
        bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 32'h4444;
        step();
        bus.alu_valid = 0;
        chk("rstmid_wb_enable_pre", bus.wb_enable, 1);
        chk("rstmid_err_pre", bus.err, 1);
        reset = 1; bus.rs1_reg = 5'd4;
        step();
        reset = 0;
        chk("rstmid_wb_enable", bus.wb_enable, 0);
        chk("rstmid_err", bus.err, 0);
        @(negedge clk);
        chk("rstmid_busy", bus.rs1_busy, 0);
        chk("rstmid_idle", bus.idle, 1);

        // Randomized traffic against the pending-count model
        do_reset();
        for (int r = 0; r < 32; r++) pend[r] = 0;
        m_en = 0; m_reg = 0; m_data = 0; m_prio_alu = 0;
        a_act = 0; l_act = 0;
        for (int c = 0; c < 700; c++) begin
            bit exp_ar, exp_lr, exp_ir, exp_idle;
            if (!a_act && owed.size() > 0 && $urandom_range(0, 1) == 1) begin
                a_act = 1; bus.alu_rd = 5'(owed.pop_front()); bus.alu_data = $urandom;
            end else if (!a_act && $urandom_range(0, 15) == 0) begin
                a_act = 1; bus.alu_rd = 5'd0; bus.alu_data = $urandom;
            end
            if (!l_act && owed.size() > 0 && $urandom_range(0, 1) == 1) begin
                l_act = 1; bus.ld_rd = 5'(owed.pop_front()); bus.ld_data = $urandom;
            end else if (!l_act && $urandom_range(0, 15) == 0) begin
                l_act = 1; bus.ld_rd = 5'd0; bus.ld_data = $urandom;
            end
            bus.alu_valid   = a_act;
            bus.ld_valid    = l_act;
            bus.issue_valid = (c < 500) && ($urandom_range(0, 2) != 0);
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.rs1_reg     = 5'($urandom_range(0, 7));
            bus.rs2_reg     = 5'($urandom_range(0, 7));
            @(negedge clk);
            exp_ar = a_act && (!l_act || m_prio_alu);
            exp_lr = l_act && (!a_act || !m_prio_alu);
            exp_ir = (bus.issue_rd == 0) || (pend[bus.issue_rd] < 3) ||
                     (m_en && m_reg == bus.issue_rd);
            exp_idle = !m_en;
            for (int r = 0; r < 32; r++) if (pend[r] != 0) exp_idle = 0;
            chk("rnd_alu_ready", bus.alu_ready, exp_ar);
            chk("rnd_ld_ready", bus.ld_ready, exp_lr);
            chk("rnd_issue_ready", bus.issue_ready, exp_ir);
            chk("rnd_rs1_busy", bus.rs1_busy, pend[bus.rs1_reg] != 0);
            chk("rnd_rs2_busy", bus.rs2_busy, pend[bus.rs2_reg] != 0);
            chk("rnd_idle", bus.idle, exp_idle);
            if (bus.issue_valid && exp_ir && bus.issue_rd != 0) begin
                pend[bus.issue_rd]++;
                owed.push_back(int'(bus.issue_rd));
            end
            if (m_en) pend[m_reg]--;
            if (a_act && l_act) m_prio_alu = !m_prio_alu;
            if (exp_ar) begin
                m_en = (bus.alu_rd != 0); m_reg = bus.alu_rd; m_data = bus.alu_data; a_act = 0;
            end else if (exp_lr) begin
                m_en = (bus.ld_rd != 0); m_reg = bus.ld_rd; m_data = bus.ld_data; l_act = 0;
            end else begin
                m_en = 0;
            end
            step();
            chk("rnd_wb_enable", bus.wb_enable, m_en);
            if (m_en) begin
                chk("rnd_wb_reg", bus.wb_reg, m_reg);
                chk("rnd_wb_data", bus.wb_data, m_data);
            end
            chk("rnd_err", bus.err, 0);
        end
        clr_inputs();
        repeat (2) step();
        chk("rnd_final_idle", bus.idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
